// File: rtl/unit_arr_broadcast_if.sv
// Element type shared by the averaging path, plus the vector-in / beat-out
// bus of the unit-vector broadcaster.
package unit_pkg;
  // Unsigned Q1.15 fixed point: 16'h8000 is 1.0, 16'h4000 is 0.5.
  typedef logic [15:0] unit_t;
endpackage

interface unit_arr_broadcast_if #(
  parameter int N   = 16,
  parameter int LEN = 32
);
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = (LEN > 1) ? $clog2(LEN) : 1;

  logic                          in_valid;
  logic                          in_ready;
  unit_pkg::unit_t [LEN-1:0]     in;
  logic                          out_valid;
  logic                          out_ready;
  unit_pkg::unit_t               out_data;
  logic [DW-1:0]                 out_dst;
  logic [EW-1:0]                 out_elem;
  logic                          done;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out_data, out_dst, out_elem, done
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out_data, out_dst, out_elem, done
  );
endinterface

// File: rtl/unit_arr_broadcast.sv
// Latches one averaged unit vector and streams it element by element to each
// of N destinations in turn over a single tagged valid/ready beat bus.
module unit_arr_broadcast #(
  parameter int N   = 16,
  parameter int LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  unit_arr_broadcast_if.slave bus
);
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                    state;
  unit_pkg::unit_t [LEN-1:0] vec_buf;
  logic [DW-1:0]             dst;
  logic [EW-1:0]             elem;
  logic                      done_q;
  logic                      last_elem;
  logic                      last_dst;

  assign last_elem = (elem == EW'(LEN - 1));
  assign last_dst  = (dst == DW'(N - 1));

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      // NOTE: the vector buffer is reset on purpose so out_data reads 0 after
      // reset; storage that needs no defined reset value is normally left alone.
      vec_buf <= '0;
      dst     <= '0;
      elem    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            vec_buf <= bus.in;
            dst     <= '0;
            elem    <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (last_elem) begin
              elem <= '0;
              if (last_dst) begin
                dst    <= '0;
                state  <= IDLE;
                done_q <= 1'b1;
              end else begin
                dst <= dst + 1'b1;
              end
            end else begin
              elem <= elem + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == SEND);
  assign bus.out_dst   = dst;
  assign bus.out_elem  = elem;
  assign bus.done      = done_q;

  // With a single element the index register carries no information.
  if (LEN == 1) begin : g_single_elem
    assign bus.out_data = vec_buf[0];
  end else begin : g_multi_elem
    assign bus.out_data = vec_buf[elem];
  end
endmodule
